// File: rtl/wb_commit_stage.sv
// ---------------------------------------------------------------------------
// wb_commit_stage
//
// Registered write-back / commit stage sitting between MEM and the GPR/CSR
// register files. One MEM result is captured per valid/ready handshake and
// presented for exactly one cycle. In that cycle the stage drives the write
// strobes, the forwarding data, the commit pulse and the halt status.
//
// For loads, the stage extracts the addressed lane from the naturally
// aligned memory word. It then sign- or zero-extends that lane to XLEN.
// A system-halt op latches the stage into HALTED. Only reset leaves HALTED.
//
// Optional feature macro: WB_PERF_CNT_EN
//   When defined, the build adds the PERF_W parameter and the WB_o_commit_cnt
//   port. That port is a free-running retired-instruction counter.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   WB_i_valid / WB_o_ready        input handshake
//   WB_i_pc, WB_i_inst             PC / instruction of the incoming op
//   WB_i_ALU_ALUout                ALU result (low bits = load byte offset)
//   WB_i_ALU_CSR_out               CSR write data
//   WB_i_rdata                     aligned memory word for loads
//   WB_i_load_type                 load funct3
//   WB_i_rd, WB_i_csr_rd           destination indices
//   WB_i_write_gpr/_csr, WB_i_mem_to_reg, WB_i_system_halt   control
//   WB_o_rf_busW, WB_o_csr_busW    write data
//   WB_o_rd, WB_o_csr_rd           registered indices
//   WB_o_RegWr, WB_o_CSRWr         one-cycle write strobes
//   WB_o_fwd_valid                 WB_o_rf_busW is valid forwarding data
//   WB_o_commit                    one-cycle retire pulse
//   WB_o_pc, WB_o_inst             retiring op
//   WB_o_system_halt               sticky halt
//   WB_o_misalign                  retiring load was misaligned
//   WB_o_commit_cnt                retire counter (WB_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module wb_commit_stage #(
    parameter int XLEN   = 32,
    parameter int GPR_AW = 5,
    parameter int CSR_AW = 2
`ifdef WB_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WB_i_valid,
    output logic              WB_o_ready,
    input  logic [31:0]       WB_i_pc,
    input  logic [31:0]       WB_i_inst,
    input  logic [XLEN-1:0]   WB_i_ALU_ALUout,
    input  logic [XLEN-1:0]   WB_i_ALU_CSR_out,
    input  logic [XLEN-1:0]   WB_i_rdata,
    input  logic [2:0]        WB_i_load_type,
    input  logic [GPR_AW-1:0] WB_i_rd,
    input  logic [CSR_AW-1:0] WB_i_csr_rd,
    input  logic              WB_i_write_gpr,
    input  logic              WB_i_write_csr,
    input  logic              WB_i_mem_to_reg,
    input  logic              WB_i_system_halt,
    output logic [XLEN-1:0]   WB_o_rf_busW,
    output logic [XLEN-1:0]   WB_o_csr_busW,
    output logic [GPR_AW-1:0] WB_o_rd,
    output logic [CSR_AW-1:0] WB_o_csr_rd,
    output logic              WB_o_RegWr,
    output logic              WB_o_CSRWr,
    output logic              WB_o_fwd_valid,
    output logic              WB_o_commit,
    output logic [31:0]       WB_o_pc,
    output logic [31:0]       WB_o_inst,
    output logic              WB_o_system_halt,
    output logic              WB_o_misalign
`ifdef WB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] WB_o_commit_cnt
`endif
);

    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic              r_validQ;
    logic              r_haltQ;
    logic [31:0]       r_pcQ;
    logic [31:0]       r_instQ;
    logic [XLEN-1:0]   r_aluOutQ;
    logic [XLEN-1:0]   r_csrOutQ;
    logic [XLEN-1:0]   r_rdataQ;
    logic [2:0]        r_loadTypeQ;
    logic [GPR_AW-1:0] r_rdQ;
    logic [CSR_AW-1:0] r_csrRdQ;
    logic              r_writeGprQ;
    logic              r_writeCsrQ;
    logic              r_memToRegQ;

    logic              w_accept;
    logic              w_retireHalt;
    logic [OFFW-1:0]   w_off;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_extracted;
    logic              w_misRaw;

    assign w_retireHalt = r_validQ & r_haltQ;
    assign WB_o_ready   = (r_state == RUN) & ~w_retireHalt;
    assign w_accept     = WB_i_valid & WB_o_ready;

    // The stage leaves RUN in the cycle the halt op retires.
    // No event other than reset brings it back to RUN.
    always_comb begin
        w_nextState = r_state;
        if (r_state == RUN && w_retireHalt) begin
            w_nextState = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Single-entry pipeline register. The entry always drains after one
    // cycle, so valid drops whenever nothing new is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_validQ    <= 1'b0;
            r_haltQ     <= 1'b0;
            r_pcQ       <= '0;
            r_instQ     <= '0;
            r_aluOutQ   <= '0;
            r_csrOutQ   <= '0;
            r_rdataQ    <= '0;
            r_loadTypeQ <= '0;
            r_rdQ       <= '0;
            r_csrRdQ    <= '0;
            r_writeGprQ <= 1'b0;
            r_writeCsrQ <= 1'b0;
            r_memToRegQ <= 1'b0;
        end else if (w_accept) begin
            r_validQ    <= 1'b1;
            r_haltQ     <= WB_i_system_halt;
            r_pcQ       <= WB_i_pc;
            r_instQ     <= WB_i_inst;
            r_aluOutQ   <= WB_i_ALU_ALUout;
            r_csrOutQ   <= WB_i_ALU_CSR_out;
            r_rdataQ    <= WB_i_rdata;
            r_loadTypeQ <= WB_i_load_type;
            r_rdQ       <= WB_i_rd;
            r_csrRdQ    <= WB_i_csr_rd;
            r_writeGprQ <= WB_i_write_gpr;
            r_writeCsrQ <= WB_i_write_csr;
            r_memToRegQ <= WB_i_mem_to_reg;
        end else begin
            r_validQ    <= 1'b0;
        end
    end

    // Load lane extraction. The byte offset shifts the addressed lane down
    // to bit 0. The lane is then extended to XLEN. The size casts of signed
    // lanes sign-extend, and the casts of unsigned lanes zero-extend.
    // For XLEN=32, LD and LWU behave exactly like LW.
    always_comb begin
        w_off       = r_aluOutQ[OFFW-1:0];
        w_shifted   = r_rdataQ >> {w_off, 3'b000};
        w_extracted = XLEN'($signed(w_shifted[31:0]));
        w_misRaw    = (w_off[1:0] != 2'b00);
        case (r_loadTypeQ)
            3'b000: begin
                w_extracted = XLEN'($signed(w_shifted[7:0]));
                w_misRaw    = 1'b0;
            end
            3'b001: begin
                w_extracted = XLEN'($signed(w_shifted[15:0]));
                w_misRaw    = w_off[0];
            end
            3'b011: begin
                if (XLEN == 64) begin
                    w_extracted = r_rdataQ;
                    w_misRaw    = (w_off != '0);
                end
            end
            3'b100: begin
                w_extracted = XLEN'(w_shifted[7:0]);
                w_misRaw    = 1'b0;
            end
            3'b101: begin
                w_extracted = XLEN'(w_shifted[15:0]);
                w_misRaw    = w_off[0];
            end
            3'b110: begin
                w_extracted = XLEN'(w_shifted[31:0]);
            end
            default: begin
            end
        endcase
    end

    // A misaligned load still retires and still strobes, but it writes zero.
    assign WB_o_rf_busW     = r_memToRegQ ? (w_misRaw ? '0 : w_extracted) : r_aluOutQ;
    assign WB_o_misalign    = r_validQ & r_memToRegQ & w_misRaw;
    assign WB_o_csr_busW    = r_csrOutQ;
    assign WB_o_rd          = r_rdQ;
    assign WB_o_csr_rd      = r_csrRdQ;
    assign WB_o_RegWr       = r_validQ & r_writeGprQ & (r_rdQ != '0);
    assign WB_o_CSRWr       = r_validQ & r_writeCsrQ;
    assign WB_o_fwd_valid   = WB_o_RegWr;
    assign WB_o_commit      = r_validQ;
    assign WB_o_pc          = r_pcQ;
    assign WB_o_inst        = r_instQ;
    assign WB_o_system_halt = (r_state == HALTED) | w_retireHalt;

`ifdef WB_PERF_CNT_EN
    // Retire counter. It wraps naturally modulo 2^PERF_W.
    logic [PERF_W-1:0] r_commitCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commitCnt <= '0;
        end else if (r_validQ) begin
            r_commitCnt <= r_commitCnt + 1'b1;
        end
    end

    assign WB_o_commit_cnt = r_commitCnt;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_stage
//
// Directed, table-driven bench for wb_commit_stage (XLEN=32).
// Single-cycle load/ALU/CSR cases come from a vector table. Hand-written
// sequences cover the multi-cycle cases:
//   - behaviour while reset is held and after it is released
//   - back-to-back streaming
//   - halt
//   - async reset in the middle of an op
//   - the optional retire counter
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_commit_stage;

    localparam int XLEN   = 32;
    localparam int GPR_AW = 5;
    localparam int CSR_AW = 2;
`ifdef WB_PERF_CNT_EN
    localparam int PERF_W = 4;
`endif

    logic              clk;
    logic              rst_n;
    logic              WB_i_valid;
    logic              WB_o_ready;
    logic [31:0]       WB_i_pc;
    logic [31:0]       WB_i_inst;
    logic [XLEN-1:0]   WB_i_ALU_ALUout;
    logic [XLEN-1:0]   WB_i_ALU_CSR_out;
    logic [XLEN-1:0]   WB_i_rdata;
    logic [2:0]        WB_i_load_type;
    logic [GPR_AW-1:0] WB_i_rd;
    logic [CSR_AW-1:0] WB_i_csr_rd;
    logic              WB_i_write_gpr;
    logic              WB_i_write_csr;
    logic              WB_i_mem_to_reg;
    logic              WB_i_system_halt;
    logic [XLEN-1:0]   WB_o_rf_busW;
    logic [XLEN-1:0]   WB_o_csr_busW;
    logic [GPR_AW-1:0] WB_o_rd;
    logic [CSR_AW-1:0] WB_o_csr_rd;
    logic              WB_o_RegWr;
    logic              WB_o_CSRWr;
    logic              WB_o_fwd_valid;
    logic              WB_o_commit;
    logic [31:0]       WB_o_pc;
    logic [31:0]       WB_o_inst;
    logic              WB_o_system_halt;
    logic              WB_o_misalign;
`ifdef WB_PERF_CNT_EN
    logic [PERF_W-1:0] WB_o_commit_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    wb_commit_stage #(
        .XLEN   (XLEN),
        .GPR_AW (GPR_AW),
        .CSR_AW (CSR_AW)
`ifdef WB_PERF_CNT_EN
        ,
        .PERF_W (PERF_W)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .WB_i_valid       (WB_i_valid),
        .WB_o_ready       (WB_o_ready),
        .WB_i_pc          (WB_i_pc),
        .WB_i_inst        (WB_i_inst),
        .WB_i_ALU_ALUout  (WB_i_ALU_ALUout),
        .WB_i_ALU_CSR_out (WB_i_ALU_CSR_out),
        .WB_i_rdata       (WB_i_rdata),
        .WB_i_load_type   (WB_i_load_type),
        .WB_i_rd          (WB_i_rd),
        .WB_i_csr_rd      (WB_i_csr_rd),
        .WB_i_write_gpr   (WB_i_write_gpr),
        .WB_i_write_csr   (WB_i_write_csr),
        .WB_i_mem_to_reg  (WB_i_mem_to_reg),
        .WB_i_system_halt (WB_i_system_halt),
        .WB_o_rf_busW     (WB_o_rf_busW),
        .WB_o_csr_busW    (WB_o_csr_busW),
        .WB_o_rd          (WB_o_rd),
        .WB_o_csr_rd      (WB_o_csr_rd),
        .WB_o_RegWr       (WB_o_RegWr),
        .WB_o_CSRWr       (WB_o_CSRWr),
        .WB_o_fwd_valid   (WB_o_fwd_valid),
        .WB_o_commit      (WB_o_commit),
        .WB_o_pc          (WB_o_pc),
        .WB_o_inst        (WB_o_inst),
        .WB_o_system_halt (WB_o_system_halt),
        .WB_o_misalign    (WB_o_misalign)
`ifdef WB_PERF_CNT_EN
        ,
        .WB_o_commit_cnt  (WB_o_commit_cnt)
`endif
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  loadType;
        logic        memToReg;
        logic        writeGpr;
        logic        writeCsr;
        logic [4:0]  rd;
        logic [31:0] aluOut;
        logic [31:0] csrOut;
        logic [31:0] rdata;
        logic [31:0] expBusW;
        logic        expRegWr;
        logic        expCsrWr;
        logic        expMisalign;
    } vec_t;

    vec_t vecs[$];

    // Compare one value and report a failure line on mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        WB_i_valid       = 1'b0;
        WB_i_pc          = '0;
        WB_i_inst        = '0;
        WB_i_ALU_ALUout  = '0;
        WB_i_ALU_CSR_out = '0;
        WB_i_rdata       = '0;
        WB_i_load_type   = '0;
        WB_i_rd          = '0;
        WB_i_csr_rd      = '0;
        WB_i_write_gpr   = 1'b0;
        WB_i_write_csr   = 1'b0;
        WB_i_mem_to_reg  = 1'b0;
        WB_i_system_halt = 1'b0;
    endtask

    // Drive one vector on the falling edge so it is captured on the next rise
    task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
        @(negedge clk);
        clearInputs();
        WB_i_valid       = 1'b1;
        WB_i_pc          = pc;
        WB_i_inst        = 32'h0000_0013 ^ pc;
        WB_i_load_type   = v.loadType;
        WB_i_mem_to_reg  = v.memToReg;
        WB_i_write_gpr   = v.writeGpr;
        WB_i_write_csr   = v.writeCsr;
        WB_i_rd          = v.rd;
        WB_i_csr_rd      = 2'd2;
        WB_i_ALU_ALUout  = v.aluOut;
        WB_i_ALU_CSR_out = v.csrOut;
        WB_i_rdata       = v.rdata;
    endtask

    task automatic addVec(input string name, input logic [2:0] lt, input logic m2r,
                          input logic wg, input logic wc, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] csr,
                          input logic [31:0] rdata, input logic [31:0] busW,
                          input logic regWr, input logic csrWr, input logic mis);
        vec_t v;
        v.name = name; v.loadType = lt; v.memToReg = m2r; v.writeGpr = wg;
        v.writeCsr = wc; v.rd = rd; v.aluOut = alu; v.csrOut = csr; v.rdata = rdata;
        v.expBusW = busW; v.expRegWr = regWr; v.expCsrWr = csrWr; v.expMisalign = mis;
        vecs.push_back(v);
    endtask

    // Main sequence
    initial begin
        // Fill the vector table. The rdata bytes from high to low are 80 FF 7F 01.
        addVec("LB_off2",   3'b000, 1, 1, 0, 5'd5, 32'h1002, 0, 32'h80FF7F01, 32'hFFFFFFFF, 1, 0, 0);
        addVec("LBU_off2",  3'b100, 1, 1, 0, 5'd5, 32'h1002, 0, 32'h80FF7F01, 32'h000000FF, 1, 0, 0);
        addVec("LH_off2",   3'b001, 1, 1, 0, 5'd6, 32'h1002, 0, 32'h80FF7F01, 32'hFFFF80FF, 1, 0, 0);
        addVec("LHU_off2",  3'b101, 1, 1, 0, 5'd6, 32'h1002, 0, 32'h80FF7F01, 32'h000080FF, 1, 0, 0);
        addVec("LB_off1",   3'b000, 1, 1, 0, 5'd7, 32'h1001, 0, 32'h80FF7F01, 32'h0000007F, 1, 0, 0);
        addVec("LB_off3",   3'b000, 1, 1, 0, 5'd7, 32'h1003, 0, 32'h80FF7F01, 32'hFFFFFF80, 1, 0, 0);
        addVec("LHU_off0",  3'b101, 1, 1, 0, 5'd8, 32'h1000, 0, 32'h80FF7F01, 32'h00007F01, 1, 0, 0);
        addVec("LW_off0",   3'b010, 1, 1, 0, 5'd9, 32'h1000, 0, 32'h80FF7F01, 32'h80FF7F01, 1, 0, 0);
        addVec("LH_off1",   3'b001, 1, 1, 0, 5'd5, 32'h1001, 0, 32'h80FF7F01, 32'h00000000, 1, 0, 1);
        addVec("LW_off2",   3'b010, 1, 1, 0, 5'd5, 32'h1002, 0, 32'h80FF7F01, 32'h00000000, 1, 0, 1);
        addVec("ALU_rd0",   3'b010, 0, 1, 0, 5'd0, 32'h1234, 0, 32'h80FF7F01, 32'h00001234, 0, 0, 0);
        addVec("ALU_rd7",   3'b010, 0, 1, 0, 5'd7, 32'hDEADBEEF, 0, 0,         32'hDEADBEEF, 1, 0, 0);
        addVec("CSR_write", 3'b001, 0, 0, 1, 5'd3, 32'h1001, 32'hCAFEF00D, 0,  32'h00001001, 0, 1, 0);

        // Hold reset while a valid op is presented. Nothing may retire.
        clearInputs();
        rst_n            = 1'b0;
        WB_i_valid       = 1'b1;
        WB_i_mem_to_reg  = 1'b1;
        WB_i_write_gpr   = 1'b1;
        WB_i_load_type   = 3'b010;
        WB_i_rd          = 5'd4;
        WB_i_ALU_ALUout  = 32'h2000;
        WB_i_rdata       = 32'h11223344;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_RegWr",  WB_o_RegWr, 0);
        checkOutput("rst_commit", WB_o_commit, 0);
        checkOutput("rst_CSRWr",  WB_o_CSRWr, 0);
        checkOutput("rst_ready",  WB_o_ready, 1);
        checkOutput("rst_halt",   WB_o_system_halt, 0);
        checkOutput("rst_busW",   WB_o_rf_busW, 0);
        checkOutput("rst_mis",    WB_o_misalign, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_RegWr",  WB_o_RegWr, 1);
        checkOutput("postrst_commit", WB_o_commit, 1);
        checkOutput("postrst_busW",   WB_o_rf_busW, 32'h11223344);
        checkOutput("postrst_rd",     WB_o_rd, 4);

        // Table vectors arrive back to back. Each one is checked one cycle
        // after it is captured.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 32'h400 + 32'(i * 4));
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_busW"},  WB_o_rf_busW,   vecs[i].expBusW);
            checkOutput({vecs[i].name, "_RegWr"}, WB_o_RegWr,     vecs[i].expRegWr);
            checkOutput({vecs[i].name, "_fwd"},   WB_o_fwd_valid, vecs[i].expRegWr);
            checkOutput({vecs[i].name, "_CSRWr"}, WB_o_CSRWr,     vecs[i].expCsrWr);
            checkOutput({vecs[i].name, "_mis"},   WB_o_misalign,  vecs[i].expMisalign);
            checkOutput({vecs[i].name, "_commit"}, WB_o_commit,   1);
            checkOutput({vecs[i].name, "_rd"},    WB_o_rd,        vecs[i].rd);
            if (vecs[i].expCsrWr) begin
                checkOutput({vecs[i].name, "_csrBus"}, WB_o_csr_busW, vecs[i].csrOut);
                checkOutput({vecs[i].name, "_csrRd"},  WB_o_csr_rd,   2);
            end
        end

        // An idle cycle drains the entry. The misalign flag lasts one cycle only.
        @(negedge clk);
        clearInputs();
        @(posedge clk);
        #1;
        checkOutput("idle_commit", WB_o_commit, 0);
        checkOutput("idle_RegWr",  WB_o_RegWr, 0);
        checkOutput("idle_mis",    WB_o_misalign, 0);

        // Four ops stream back to back. Each PC comes out one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clearInputs();
            WB_i_valid     = 1'b1;
            WB_i_pc        = 32'h100 + 32'(i * 4);
            WB_i_inst      = 32'hA000_0000 + 32'(i);
            WB_i_write_gpr = 1'b1;
            WB_i_rd        = 5'd10;
            checkOutput($sformatf("b2b_ready%0d", i), WB_o_ready, 1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b_commit%0d", i), WB_o_commit, 1);
            checkOutput($sformatf("b2b_pc%0d", i),     WB_o_pc, 32'h100 + 32'(i * 4));
            checkOutput($sformatf("b2b_inst%0d", i),   WB_o_inst, 32'hA000_0000 + 32'(i));
        end
        @(negedge clk);
        clearInputs();
        @(posedge clk);
        #1;
        checkOutput("b2b_drain", WB_o_commit, 0);

        // A halt op is followed by more valid ops. Only the halt op retires.
        @(negedge clk);
        clearInputs();
        WB_i_valid       = 1'b1;
        WB_i_pc          = 32'h200;
        WB_i_system_halt = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("halt_commit", WB_o_commit, 1);
        checkOutput("halt_pc",     WB_o_pc, 32'h200);
        checkOutput("halt_out",    WB_o_system_halt, 1);
        checkOutput("halt_ready",  WB_o_ready, 0);
        @(negedge clk);
        clearInputs();
        WB_i_valid     = 1'b1;
        WB_i_pc        = 32'h204;
        WB_i_write_gpr = 1'b1;
        WB_i_rd        = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("halted_commit%0d", i), WB_o_commit, 0);
            checkOutput($sformatf("halted_RegWr%0d", i),  WB_o_RegWr, 0);
            checkOutput($sformatf("halted_out%0d", i),    WB_o_system_halt, 1);
            checkOutput($sformatf("halted_ready%0d", i),  WB_o_ready, 0);
        end

        // Reset releases the halt.
        @(negedge clk);
        clearInputs();
        rst_n = 1'b0;
        #1;
        checkOutput("unhalt_out",   WB_o_system_halt, 0);
        checkOutput("unhalt_ready", WB_o_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // An async reset that arrives mid-op drops the in-flight entry.
        @(negedge clk);
        WB_i_valid     = 1'b1;
        WB_i_write_gpr = 1'b1;
        WB_i_rd        = 5'd12;
        WB_i_ALU_ALUout = 32'h55;
        @(posedge clk);
        #1;
        checkOutput("midop_before", WB_o_RegWr, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midop_RegWr",  WB_o_RegWr, 0);
        checkOutput("midop_commit", WB_o_commit, 0);
        @(negedge clk);
        clearInputs();
        rst_n = 1'b1;

`ifdef WB_PERF_CNT_EN
        // With a 4-bit counter, 15 commits reach the all-ones value and
        // one more commit wraps the counter to 0.
        checkOutput("cnt_zero", WB_o_commit_cnt, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            WB_i_valid = 1'b1;
            WB_i_pc    = 32'(i);
            @(posedge clk);
            #1;
            if (i == 15) begin
                checkOutput("cnt_max", WB_o_commit_cnt, 4'hF);
            end
        end
        @(negedge clk);
        clearInputs();
        @(posedge clk);
        #1;
        checkOutput("cnt_wrap", WB_o_commit_cnt, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
